// File: rtl/rom_loader.sv
// Framed byte-stream loader for the instruction ROM write port.
// Keeps the CPU held in reset until a full image has been written and its checksum matched.
module rom_loader #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO,
    S_WRITE, S_SUM_HI, S_SUM_LO, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_n;
  logic [7:0]            hi_q;
  logic [15:0]           len_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  xfer;
  logic                  armable;
  logic [15:0]           pair;

  assign xfer    = in_valid & in_ready;
  assign armable = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign pair    = {hi_q, in_data};

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        busy     = 1'b0;
        done     = (state == S_DONE);
        error    = (state == S_ERROR);
        cpu_hold = (state != S_DONE);
        if (start) state_n = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (xfer) state_n = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (32'(pair) > 32'(MAX_WORDS)) state_n = S_ERROR;
          else if (pair == 16'd0)         state_n = S_SUM_HI;
          else                            state_n = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        in_ready = 1'b1;
        if (xfer) state_n = S_DAT_LO;
      end
      S_DAT_LO: begin
        in_ready = 1'b1;
        if (xfer) state_n = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        // mem_addr still holds the address being written, so +1 is the word count
        if (32'(mem_addr) + 32'd1 == 32'(len_q)) state_n = S_SUM_HI;
        else                                     state_n = S_DAT_HI;
      end
      S_SUM_HI: begin
        in_ready = 1'b1;
        if (xfer) state_n = S_SUM_LO;
      end
      S_SUM_LO: begin
        in_ready = 1'b1;
        if (xfer) state_n = (DATA_WIDTH'(pair) == sum_q) ? S_DONE : S_ERROR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hi_q      <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (armable && start) begin
        mem_addr <= '0;
        sum_q    <= '0;
      end
      if (xfer && (state == S_LEN_HI || state == S_DAT_HI || state == S_SUM_HI))
        hi_q <= in_data;
      if (xfer && state == S_LEN_LO)
        len_q <= pair;
      if (xfer && state == S_DAT_LO)
        mem_wdata <= DATA_WIDTH'(pair);
      if (state == S_WRITE) begin
        sum_q    <= sum_q + mem_wdata;
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: expected ROM writes are queued as words are sent
// and checked against each mem_we strobe; end-of-load status checked per scenario.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy, done, error, cpu_hold;

  int vectors = 0;
  int miscompares = 0;
  int total_writes = 0;
  int writes_before;
  bit jitter = 1'b0;
  logic [31:0] exp_q[$];

  rom_loader #(.ADDR_WIDTH(15), .DATA_WIDTH(16), .MAX_WORDS(4096)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued {addr,data}.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      total_writes++;
      if (exp_q.size() == 0) chk("unexpected_write", {1'b0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      else chk("write", {1'b0, mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (jitter) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("ready_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [14:0] addr, input logic [15:0] w);
    exp_q.push_back({1'b0, addr, w});
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input logic exp_done, input logic exp_err);
    int t;
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk({tag, "_timeout"}, 32'(t), 32'd0);
    chk({tag, "_status"}, {28'd0, busy, done, error, cpu_hold},
        {28'd0, 1'b0, exp_done, exp_err, ~exp_done});
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic frame_ok();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_word(15'd0, 16'h1234);
    send_word(15'd1, 16'hABCD);
    send_byte(8'hBE); send_byte(8'h01);
  endtask

  initial begin
    #2;
    chk("reset_outputs", {22'd0, in_ready, mem_we, busy, done, error, cpu_hold, 4'd0},
        {22'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
    chk("reset_addr_data", {1'b0, mem_addr, mem_wdata}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: two-word image, good checksum
    frame_ok();
    wait_end("s1", 1'b1, 1'b0);

    // 2: same image, bad checksum
    pulse_start();
    chk("s2_start_clears", {29'd0, busy, done, cpu_hold}, {29'd0, 1'b1, 1'b0, 1'b1});
    send_byte(8'h00); send_byte(8'h02);
    send_word(15'd0, 16'h1234);
    send_word(15'd1, 16'hABCD);
    send_byte(8'hBE); send_byte(8'h02);
    wait_end("s2", 1'b0, 1'b1);

    // 3: oversize length rejected right after LEN_LO
    writes_before = total_writes;
    pulse_start();
    send_byte(8'h10); send_byte(8'h01);
    chk("s3_error_now", {30'd0, error, in_ready}, {30'd0, 1'b1, 1'b0});
    wait_end("s3", 1'b0, 1'b1);
    chk("s3_no_writes", 32'(total_writes - writes_before), 32'd0);

    // 3b: exactly MAX_WORDS is accepted as a length
    pulse_start();
    send_byte(8'h10); send_byte(8'h00);
    chk("s3b_accept_max", {30'd0, busy, error}, {30'd0, 1'b1, 1'b0});
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // 4: empty image
    writes_before = total_writes;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_end("s4a", 1'b1, 1'b0);
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    wait_end("s4b", 1'b0, 1'b1);
    chk("s4_no_writes", 32'(total_writes - writes_before), 32'd0);

    // 5: irregular valid and a stray start mid-frame
    jitter = 1'b1;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_word(15'd0, 16'h1234);
    pulse_start();
    chk("s5_still_busy", {31'd0, busy}, 32'd1);
    send_word(15'd1, 16'hABCD);
    send_byte(8'hBE); send_byte(8'h01);
    wait_end("s5", 1'b1, 1'b0);
    jitter = 1'b0;

    // 6: reset after first word, then a clean reload
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_word(15'd0, 16'h1234);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("s6_reset_outputs", {22'd0, in_ready, mem_we, busy, done, error, cpu_hold, 4'd0},
        {22'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
    chk("s6_reset_addr", {17'd0, mem_addr}, 32'd0);
    chk("s6_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame_ok();
    wait_end("s6", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
